mult_pipe_unit: RTL and testbench

Four-stage pipelined 32x32 integer multiplier that runs beside the main EX/MEM/WB path and writes its result directly into register `rd`. It sits directly upstream of the register-file forwarding/stall unit. It supplies the per-stage destination tags (`o_p1_mult_rd`, `o_p2_mult_rd`, `o_p3_mult_rd`), which the forwarding unit uses to stall ID on a pending product. It also supplies the completion triple (`o_mult_ready`, `o_mult_rd`, `o_mult_result`), which the forwarding unit uses to forward the finished product into ID.

---
 rtl/mult_pipe_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_pipe_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mult_pipe_unit.sv
// mult_pipe_unit: four-stage pipelined DATA_W x DATA_W integer multiplier (MULT/MULTU)
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_valid, i_signed      : issue strobe, signed/unsigned select
//   i_rs_data, i_rt_data   : operands A and B
//   i_rd                   : destination register tag (0 = discard write)
//   o_p1/p2/p3_mult_rd     : per-stage pending tags (0 when stage empty)
//   o_mult_ready/rd/result : completion pulse, tag and low product word
//   o_hi, o_lo             : HI/LO registers when MULT_HILO_EN is defined, else 0
module mult_pipe_unit #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_rs_data,
   input  logic [DATA_W-1:0] i_rt_data,
   input  logic [RD_W-1:0]   i_rd,
   output logic [RD_W-1:0]   o_p1_mult_rd,
   output logic [RD_W-1:0]   o_p2_mult_rd,
   output logic [RD_W-1:0]   o_p3_mult_rd,
   output logic              o_mult_ready,
   output logic [RD_W-1:0]   o_mult_rd,
   output logic [DATA_W-1:0] o_mult_result,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);
   localparam int H  = DATA_W / 2;
   localparam int PW = 2 * DATA_W;
   logic              p1_v_q, p2_v_q, p3_v_q;
   logic [RD_W-1:0]   p1_rd_q, p2_rd_q, p3_rd_q;
   logic              p1_neg_q, p2_neg_q, p3_neg_q;
   logic [DATA_W-1:0] p1_a_q, p1_b_q;
   logic [DATA_W-1:0] p2_ll_q, p2_lh_q, p2_hl_q, p2_hh_q;
   logic [PW-1:0]     p3_sum_q;
   logic              ready_q;
   logic [RD_W-1:0]   rd_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] a_mag_d, b_mag_d;
   logic              neg_d;
   logic [DATA_W-1:0] ll_d, lh_d, hl_d, hh_d;
   logic [DATA_W:0]   mid_d;
   logic [PW-1:0]     sum_d;
   logic [PW-1:0]     prod_d;
   logic              ready_d;
   // P1: sign-magnitude split; -(MIN) wraps to MIN, which is the correct unsigned magnitude
   always_comb begin
      a_mag_d = (i_signed && i_rs_data[DATA_W-1]) ? -i_rs_data : i_rs_data;
      b_mag_d = (i_signed && i_rt_data[DATA_W-1]) ? -i_rt_data : i_rt_data;
      neg_d   = i_signed & (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
   end
   // P2: four half-width partial products, zero-extended to full width
   always_comb begin
      ll_d = {{H{1'b0}}, p1_a_q[H-1:0]}      * {{H{1'b0}}, p1_b_q[H-1:0]};
      lh_d = {{H{1'b0}}, p1_a_q[H-1:0]}      * {{H{1'b0}}, p1_b_q[DATA_W-1:H]};
      hl_d = {{H{1'b0}}, p1_a_q[DATA_W-1:H]} * {{H{1'b0}}, p1_b_q[H-1:0]};
      hh_d = {{H{1'b0}}, p1_a_q[DATA_W-1:H]} * {{H{1'b0}}, p1_b_q[DATA_W-1:H]};
   end
   // P3: recombine; the middle sum is one bit wider so its carry survives the shift
   always_comb begin
      mid_d = {1'b0, p2_lh_q} + {1'b0, p2_hl_q};
      sum_d = {p2_hh_q, {DATA_W{1'b0}}}
            + {{(H-1){1'b0}}, mid_d, {H{1'b0}}}
            + {{DATA_W{1'b0}}, p2_ll_q};
   end
   // OUT: restore sign (two's complement negate mod 2^PW)
   always_comb begin
      prod_d  = p3_neg_q ? -p3_sum_q : p3_sum_q;
      ready_d = p3_v_q && (p3_rd_q != '0);
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         p1_v_q   <= 1'b0;
         p1_rd_q  <= '0;
         p1_neg_q <= 1'b0;
         p1_a_q   <= '0;
         p1_b_q   <= '0;
      end else begin
         p1_v_q <= i_valid;
         if (i_valid) begin
            p1_rd_q  <= i_rd;
            p1_neg_q <= neg_d;
            p1_a_q   <= a_mag_d;
            p1_b_q   <= b_mag_d;
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         p2_v_q   <= 1'b0;
         p2_rd_q  <= '0;
         p2_neg_q <= 1'b0;
         p2_ll_q  <= '0;
         p2_lh_q  <= '0;
         p2_hl_q  <= '0;
         p2_hh_q  <= '0;
      end else begin
         p2_v_q <= p1_v_q;
         if (p1_v_q) begin
            p2_rd_q  <= p1_rd_q;
            p2_neg_q <= p1_neg_q;
            p2_ll_q  <= ll_d;
            p2_lh_q  <= lh_d;
            p2_hl_q  <= hl_d;
            p2_hh_q  <= hh_d;
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         p3_v_q   <= 1'b0;
         p3_rd_q  <= '0;
         p3_neg_q <= 1'b0;
         p3_sum_q <= '0;
      end else begin
         p3_v_q <= p2_v_q;
         if (p2_v_q) begin
            p3_rd_q  <= p2_rd_q;
            p3_neg_q <= p2_neg_q;
            p3_sum_q <= sum_d;
         end
      end
   end
   // Completion outputs hold their last value between pulses
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ready_q  <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         ready_q <= ready_d;
         if (ready_d) begin
            rd_q     <= p3_rd_q;
            result_q <= prod_d[DATA_W-1:0];
         end
      end
   end
   assign o_p1_mult_rd  = p1_v_q ? p1_rd_q : '0;
   assign o_p2_mult_rd  = p2_v_q ? p2_rd_q : '0;
   assign o_p3_mult_rd  = p3_v_q ? p3_rd_q : '0;
   assign o_mult_ready  = ready_q;
   assign o_mult_rd     = rd_q;
   assign o_mult_result = result_q;
`ifdef MULT_HILO_EN
   logic              out_v_q;
   logic [PW-1:0]     out_prod_q;
   logic [DATA_W-1:0] hi_q, lo_q;
   // HI/LO trail the completion pulse by one cycle and also capture rd==0 products
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_v_q    <= 1'b0;
         out_prod_q <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         out_v_q <= p3_v_q;
         if (p3_v_q) out_prod_q <= prod_d;
         if (out_v_q) begin
            hi_q <= out_prod_q[PW-1:DATA_W];
            lo_q <= out_prod_q[DATA_W-1:0];
         end
      end
   end
   assign o_hi = hi_q;
   assign o_lo = lo_q;
`else
   logic unused_hi;
   assign unused_hi = ^prod_d[PW-1:DATA_W];
   assign o_hi = '0;
   assign o_lo = '0;
`endif
endmodule

// File: tb/tb_mult_pipe_unit.sv
// tb_mult_pipe_unit: directed self-checking bench for mult_pipe_unit
module tb_mult_pipe_unit;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_signed = 1'b0;
   logic [31:0] i_rs_data = '0;
   logic [31:0] i_rt_data = '0;
   logic [4:0]  i_rd = '0;
   logic [4:0]  o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd;
   logic        o_mult_ready;
   logic [4:0]  o_mult_rd;
   logic [31:0] o_mult_result, o_hi, o_lo;
   int errs = 0;
   int checks = 0;
`ifdef MULT_HILO_EN
   localparam bit HILO = 1'b1;
`else
   localparam bit HILO = 1'b0;
`endif
   mult_pipe_unit #(.DATA_W(32), .RD_W(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_signed(i_signed),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_rd(i_rd),
      .o_p1_mult_rd(o_p1_mult_rd), .o_p2_mult_rd(o_p2_mult_rd), .o_p3_mult_rd(o_p3_mult_rd),
      .o_mult_ready(o_mult_ready), .o_mult_rd(o_mult_rd), .o_mult_result(o_mult_result),
      .o_hi(o_hi), .o_lo(o_lo)
   );
   always #5 i_clk = ~i_clk;
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      i_valid = 1'b1; i_signed = s; i_rs_data = a; i_rt_data = b; i_rd = rd;
      cyc();
      i_valid = 1'b0;
   endtask
   task automatic test_reset();
      i_rst = 1'b1;
      cyc(); cyc();
      checks++; if (o_p1_mult_rd !== 5'd0) begin errs++; $display("FAIL reset_p1 got=%0d exp=0", o_p1_mult_rd); end
      checks++; if (o_p2_mult_rd !== 5'd0) begin errs++; $display("FAIL reset_p2 got=%0d exp=0", o_p2_mult_rd); end
      checks++; if (o_p3_mult_rd !== 5'd0) begin errs++; $display("FAIL reset_p3 got=%0d exp=0", o_p3_mult_rd); end
      checks++; if (o_mult_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", o_mult_ready); end
      checks++; if (o_mult_rd !== 5'd0) begin errs++; $display("FAIL reset_rd got=%0d exp=0", o_mult_rd); end
      checks++; if (o_mult_result !== 32'd0) begin errs++; $display("FAIL reset_result got=%h exp=0", o_mult_result); end
      checks++; if (o_hi !== 32'd0) begin errs++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
      checks++; if (o_lo !== 32'd0) begin errs++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
      i_rst = 1'b0;
      cyc();
   endtask
   task automatic test_tag_walk();
      issue(1'b0, 32'd3, 32'd5, 5'd8);
      checks++; if ({o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready} !== {5'd8, 5'd0, 5'd0, 1'b0}) begin errs++; $display("FAIL walk_e0 got=%0d/%0d/%0d/%b exp=8/0/0/0", o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready); end
      cyc();
      checks++; if ({o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready} !== {5'd0, 5'd8, 5'd0, 1'b0}) begin errs++; $display("FAIL walk_e1 got=%0d/%0d/%0d/%b exp=0/8/0/0", o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready); end
      cyc();
      checks++; if ({o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready} !== {5'd0, 5'd0, 5'd8, 1'b0}) begin errs++; $display("FAIL walk_e2 got=%0d/%0d/%0d/%b exp=0/0/8/0", o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready); end
      cyc();
      checks++; if (o_mult_ready !== 1'b1) begin errs++; $display("FAIL walk_ready got=%b exp=1", o_mult_ready); end
      checks++; if (o_mult_rd !== 5'd8) begin errs++; $display("FAIL walk_rd got=%0d exp=8", o_mult_rd); end
      checks++; if (o_mult_result !== 32'd15) begin errs++; $display("FAIL walk_result got=%h exp=f", o_mult_result); end
      checks++; if (o_p3_mult_rd !== 5'd0) begin errs++; $display("FAIL walk_p3_empty got=%0d exp=0", o_p3_mult_rd); end
      cyc();
      checks++; if (o_mult_ready !== 1'b0) begin errs++; $display("FAIL walk_pulse_len got=%b exp=0", o_mult_ready); end
      checks++; if (o_mult_result !== 32'd15) begin errs++; $display("FAIL walk_hold got=%h exp=f", o_mult_result); end
   endtask
   task automatic test_product(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(s, a, b, rd);
      cyc(); cyc(); cyc();
      checks++; if (o_mult_ready !== 1'b1 || o_mult_rd !== rd) begin errs++; $display("FAIL prod_ready a=%h b=%h s=%b got=%b/%0d exp=1/%0d", a, b, s, o_mult_ready, o_mult_rd, rd); end
      checks++; if (o_mult_result !== exp_lo) begin errs++; $display("FAIL prod_result a=%h b=%h s=%b got=%h exp=%h", a, b, s, o_mult_result, exp_lo); end
      cyc();
      checks++; if (o_hi !== (HILO ? exp_hi : 32'd0)) begin errs++; $display("FAIL prod_hi a=%h b=%h s=%b got=%h exp=%h", a, b, s, o_hi, HILO ? exp_hi : 32'd0); end
      checks++; if (o_lo !== (HILO ? exp_lo : 32'd0)) begin errs++; $display("FAIL prod_lo a=%h b=%h s=%b got=%h exp=%h", a, b, s, o_lo, HILO ? exp_lo : 32'd0); end
   endtask
   task automatic test_back_to_back();
      i_valid = 1'b1; i_signed = 1'b0;
      i_rs_data = 32'd1; i_rt_data = 32'd2; i_rd = 5'd1; cyc();
      i_rs_data = 32'd2; i_rt_data = 32'd3; i_rd = 5'd2; cyc();
      i_rs_data = 32'd3; i_rt_data = 32'd4; i_rd = 5'd3; cyc();
      i_valid = 1'b0;
      checks++; if ({o_p3_mult_rd, o_p2_mult_rd, o_p1_mult_rd} !== {5'd1, 5'd2, 5'd3}) begin errs++; $display("FAIL b2b_tags got=%0d/%0d/%0d exp=1/2/3", o_p3_mult_rd, o_p2_mult_rd, o_p1_mult_rd); end
      cyc();
      checks++; if ({o_mult_ready, o_mult_rd, o_mult_result} !== {1'b1, 5'd1, 32'd2}) begin errs++; $display("FAIL b2b_1 got=%b/%0d/%h exp=1/1/2", o_mult_ready, o_mult_rd, o_mult_result); end
      cyc();
      checks++; if ({o_mult_ready, o_mult_rd, o_mult_result} !== {1'b1, 5'd2, 32'd6}) begin errs++; $display("FAIL b2b_2 got=%b/%0d/%h exp=1/2/6", o_mult_ready, o_mult_rd, o_mult_result); end
      cyc();
      checks++; if ({o_mult_ready, o_mult_rd, o_mult_result} !== {1'b1, 5'd3, 32'd12}) begin errs++; $display("FAIL b2b_3 got=%b/%0d/%h exp=1/3/c", o_mult_ready, o_mult_rd, o_mult_result); end
      cyc();
      checks++; if (o_mult_ready !== 1'b0) begin errs++; $display("FAIL b2b_end got=%b exp=0", o_mult_ready); end
      checks++; if (o_lo !== (HILO ? 32'd12 : 32'd0)) begin errs++; $display("FAIL b2b_lo got=%h exp=%h", o_lo, HILO ? 32'd12 : 32'd0); end
   endtask
   task automatic test_rd_zero();
      issue(1'b0, 32'd7, 32'd7, 5'd0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready} !== 16'd0) begin errs++; $display("FAIL rd0_quiet cyc=%0d got=%0d/%0d/%0d/%b exp=0/0/0/0", i, o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd, o_mult_ready); end
         cyc();
      end
      checks++; if (o_mult_ready !== 1'b0) begin errs++; $display("FAIL rd0_ready got=%b exp=0", o_mult_ready); end
      checks++; if (o_mult_rd !== 5'd3 || o_mult_result !== 32'd12) begin errs++; $display("FAIL rd0_hold got=%0d/%h exp=3/c", o_mult_rd, o_mult_result); end
      checks++; if (o_lo !== (HILO ? 32'd49 : 32'd0)) begin errs++; $display("FAIL rd0_lo got=%h exp=%h", o_lo, HILO ? 32'd49 : 32'd0); end
   endtask
   task automatic test_reset_midflight();
      issue(1'b0, 32'd6, 32'd7, 5'd4);
      cyc();
      i_rst = 1'b1;
      #1;
      checks++; if ({o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd} !== 15'd0) begin errs++; $display("FAIL midrst_tags got=%0d/%0d/%0d exp=0/0/0", o_p1_mult_rd, o_p2_mult_rd, o_p3_mult_rd); end
      checks++; if ({o_mult_ready, o_mult_rd, o_mult_result} !== 38'd0) begin errs++; $display("FAIL midrst_out got=%b/%0d/%h exp=0/0/0", o_mult_ready, o_mult_rd, o_mult_result); end
      checks++; if ({o_hi, o_lo} !== 64'd0) begin errs++; $display("FAIL midrst_hilo got=%h/%h exp=0/0", o_hi, o_lo); end
      cyc();
      i_rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (o_mult_ready !== 1'b0 || o_p3_mult_rd !== 5'd0 || o_mult_rd !== 5'd0) begin errs++; $display("FAIL midrst_after cyc=%0d got=%b/%0d/%0d exp=0/0/0", i, o_mult_ready, o_p3_mult_rd, o_mult_rd); end
      end
   endtask
   initial begin
      test_reset();
      test_tag_walk();
      test_product(1'b1, 32'hFFFFFFFE, 32'd3,        5'd9,  32'hFFFFFFFF, 32'hFFFFFFFA);
      test_product(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 32'h00000001);
      test_product(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, 32'h00000001);
      test_product(1'b1, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 32'h00000000);
      test_product(1'b1, 32'h80000000, 32'd2,        5'd13, 32'hFFFFFFFF, 32'h00000000);
      test_product(1'b0, 32'h00010000, 32'h00010000, 5'd14, 32'h00000001, 32'h00000000);
      test_back_to_back();
      test_rd_zero();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
